// File: rtl/lifo_stack.sv
// lifo_stack: register-array LIFO with registered pop output and overflow/underflow flags.
//
// Build option:
//   LIFO_STICKY_ERR_EN  defined   -> ovf/unf are sticky and cleared by err_clr
//                       undefined -> ovf/unf pulse for one cycle after the event and
//                                    err_clr is ignored
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   push_enable  push request this cycle
//   push_data    data to push
//   pop_enable   pop request this cycle
//   flush        synchronous empty-the-stack request (overrides push and pop)
//   err_clr      clears the sticky error flags
//   pop_data     registered popped value
//   pop_valid    one-cycle strobe: pop_data was updated this cycle
//   top_data     current top entry, 0 when the stack is empty
//   count        number of stored entries
//   full, empty  count == DEPTH, count == 0
//   ovf, unf     overflow / underflow error flags
module lifo_stack #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_enable,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_enable,
    input  logic              flush,
    input  logic              err_clr,
    output logic [DATA_W-1:0] pop_data,
    output logic              pop_valid,
    output logic [DATA_W-1:0] top_data,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    output logic              ovf,
    output logic              unf
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     top_idx;
    logic [AW-1:0]     wr_idx;
    logic              wr_en;
    logic              accept_pop;
    logic [DATA_W-1:0] pop_src;
    logic [CW-1:0]     count_nxt;
    logic              ovf_evt;
    logic              unf_evt;

    // Only meaningful when not empty; top_data masks the empty case.
    assign top_idx  = AW'(count - CW'(1));
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign top_data = empty ? '0 : mem[top_idx];

    always_comb begin
        wr_en      = 1'b0;
        wr_idx     = AW'(count);
        accept_pop = 1'b0;
        pop_src    = top_data;
        count_nxt  = count;
        ovf_evt    = 1'b0;
        unf_evt    = 1'b0;
        if (flush) begin
            count_nxt = '0;
        end else if (push_enable && pop_enable) begin
            // Simultaneous push/pop replaces the top in place; on an empty
            // stack the pushed value bypasses straight to pop_data.
            accept_pop = 1'b1;
            if (empty) begin
                pop_src = push_data;
            end else begin
                wr_en  = 1'b1;
                wr_idx = top_idx;
            end
        end else if (push_enable) begin
            if (full) begin
                ovf_evt = 1'b1;
            end else begin
                wr_en     = 1'b1;
                count_nxt = count + CW'(1);
            end
        end else if (pop_enable) begin
            if (empty) begin
                unf_evt = 1'b1;
            end else begin
                accept_pop = 1'b1;
                count_nxt  = count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            count     <= count_nxt;
            pop_valid <= accept_pop;
            if (accept_pop) begin
                pop_data <= pop_src;
            end
`ifdef LIFO_STICKY_ERR_EN
            // A new event wins over a same-cycle clear.
            ovf <= ovf_evt | (ovf & ~err_clr);
            unf <= unf_evt | (unf & ~err_clr);
`else
            ovf <= ovf_evt;
            unf <= unf_evt;
`endif
        end
    end

`ifndef LIFO_STICKY_ERR_EN
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

    // Storage is not reset; writes are suppressed while rst is held.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
module tb_lifo_stack;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic              push_enable;
    logic [DATA_W-1:0] push_data;
    logic              pop_enable;
    logic              flush;
    logic              err_clr;
    logic [DATA_W-1:0] pop_data;
    logic              pop_valid;
    logic [DATA_W-1:0] top_data;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              ovf;
    logic              unf;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] model[$];   // reference stack contents, [$] is the top
    logic [DATA_W-1:0] sb[$];      // expected pop_data values, in order
    bit                exp_valid;
    bit                m_ovf;
    bit                m_unf;
    logic [DATA_W-1:0] m_pop_data;
    logic [DATA_W-1:0] exp_pd;
    logic [DATA_W-1:0] exp_top;

    lifo_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .push_enable(push_enable), .push_data(push_data),
        .pop_enable(pop_enable), .flush(flush), .err_clr(err_clr),
        .pop_data(pop_data), .pop_valid(pop_valid), .top_data(top_data),
        .count(count), .full(full), .empty(empty), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    // Drives one cycle of stimulus, advances the reference model and queues
    // the expected pop value; returns #1 after the active edge.
    task automatic op(input bit pu, input logic [DATA_W-1:0] d, input bit po,
                      input bit fl, input bit ec);
        bit ovf_ev, unf_ev;
        push_enable = pu; push_data = d; pop_enable = po; flush = fl; err_clr = ec;
        exp_valid = 0; ovf_ev = 0; unf_ev = 0;
        if (fl) begin
            model.delete();
        end else if (pu && po) begin
            exp_valid = 1;
            if (model.size() == 0) begin
                sb.push_back(d);
                m_pop_data = d;
            end else begin
                sb.push_back(model[$]);
                m_pop_data = model[$];
                model[$] = d;
            end
        end else if (pu) begin
            if (model.size() == DEPTH) ovf_ev = 1;
            else model.push_back(d);
        end else if (po) begin
            if (model.size() == 0) unf_ev = 1;
            else begin
                exp_valid = 1;
                m_pop_data = model.pop_back();
                sb.push_back(m_pop_data);
            end
        end
`ifdef LIFO_STICKY_ERR_EN
        m_ovf = ovf_ev | (m_ovf & ~ec);
        m_unf = unf_ev | (m_unf & ~ec);
`else
        m_ovf = ovf_ev;
        m_unf = unf_ev;
`endif
        @(posedge clk);
        #1;
        push_enable = 0; pop_enable = 0; flush = 0; err_clr = 0;
        exp_top = (model.size() == 0) ? '0 : model[$];
    endtask

    task automatic model_reset();
        model.delete(); sb.delete();
        m_ovf = 0; m_unf = 0; m_pop_data = '0; exp_valid = 0; exp_top = '0;
    endtask

    task automatic test_reset();
        rst = 1; push_enable = 0; push_data = '0; pop_enable = 0; flush = 0; err_clr = 0;
        model_reset();
        #1;
        checks++;
        if (count !== 0 || empty !== 1 || full !== 0 || pop_valid !== 0 ||
            pop_data !== 0 || ovf !== 0 || unf !== 0 || top_data !== 0) begin
            errors++;
            $display("FAIL reset: count=%0d empty=%b full=%b pv=%b pd=%h ovf=%b unf=%b top=%h, required 0/1/0/0/00/0/0/00",
                     count, empty, full, pop_valid, pop_data, ovf, unf, top_data);
        end
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_order();
        op(1, 8'h11, 0, 0, 0);
        op(1, 8'h22, 0, 0, 0);
        op(1, 8'h33, 0, 0, 0);
        checks++;
        if (count !== 3 || top_data !== 8'h33) begin
            errors++;
            $display("FAIL order_fill: count=%0d top=%h, required 3 33", count, top_data);
        end
        for (int i = 0; i < 3; i++) begin
            op(0, '0, 1, 0, 0);
            exp_pd = sb.pop_front();
            checks++;
            if (pop_valid !== 1 || pop_data !== exp_pd) begin
                errors++;
                $display("FAIL order_pop%0d: pv=%b pd=%h, required 1 %h", i, pop_valid, pop_data, exp_pd);
            end
        end
        op(0, '0, 0, 0, 0);
        checks++;
        if (empty !== 1 || pop_valid !== 0 || count !== 0) begin
            errors++;
            $display("FAIL order_empty: empty=%b pv=%b count=%0d, required 1 0 0", empty, pop_valid, count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) op(1, DATA_W'(8'hC0 + i), 0, 0, 0);
        checks++;
        if (full !== 1 || count !== 4 || ovf !== 0) begin
            errors++;
            $display("FAIL ovf_full: full=%b count=%0d ovf=%b, required 1 4 0", full, count, ovf);
        end
        op(1, 8'hEE, 0, 0, 0);
        checks++;
        if (ovf !== 1 || count !== 4 || top_data !== 8'hC3 || full !== 1) begin
            errors++;
            $display("FAIL ovf_event: ovf=%b count=%0d top=%h full=%b, required 1 4 c3 1", ovf, count, top_data, full);
        end
        op(0, '0, 0, 0, 0);
        checks++;
        if (ovf !== m_ovf) begin
            errors++;
            $display("FAIL ovf_after: ovf=%b, required %b", ovf, m_ovf);
        end
        op(0, '0, 0, 0, 1);
        checks++;
        if (ovf !== 0) begin
            errors++;
            $display("FAIL ovf_clr: ovf=%b, required 0", ovf);
        end
        op(0, '0, 0, 1, 0);
    endtask

    task automatic test_underflow();
        op(1, 8'h5A, 1, 0, 0);          // bypass makes pop_data a known non-zero value
        exp_pd = sb.pop_front();
        op(0, '0, 1, 0, 0);
        checks++;
        if (unf !== 1 || pop_valid !== 0 || pop_data !== exp_pd) begin
            errors++;
            $display("FAIL unf_event: unf=%b pv=%b pd=%h, required 1 0 %h", unf, pop_valid, pop_data, exp_pd);
        end
        op(0, '0, 0, 0, 0);
        checks++;
        if (unf !== m_unf) begin
            errors++;
            $display("FAIL unf_after: unf=%b, required %b", unf, m_unf);
        end
        op(0, '0, 1, 0, 1);             // event and clear in the same cycle
        checks++;
        if (unf !== m_unf || unf !== 1) begin
            errors++;
            $display("FAIL unf_set_vs_clr: unf=%b, required 1", unf);
        end
        op(0, '0, 0, 0, 1);
        checks++;
        if (unf !== 0) begin
            errors++;
            $display("FAIL unf_clr: unf=%b, required 0", unf);
        end
    endtask

    task automatic test_push_pop();
        op(1, 8'hA0, 0, 0, 0);
        op(1, 8'hA1, 0, 0, 0);
        op(1, 8'hB0, 1, 0, 0);
        exp_pd = sb.pop_front();
        checks++;
        if (pop_valid !== 1 || pop_data !== exp_pd || count !== 2 || top_data !== 8'hB0) begin
            errors++;
            $display("FAIL pushpop: pv=%b pd=%h count=%0d top=%h, required 1 %h 2 b0",
                     pop_valid, pop_data, count, top_data, exp_pd);
        end
        op(0, '0, 0, 1, 0);
        op(1, 8'h5C, 1, 0, 0);
        exp_pd = sb.pop_front();
        checks++;
        if (pop_valid !== 1 || pop_data !== exp_pd || count !== 0 || unf !== 0) begin
            errors++;
            $display("FAIL bypass: pv=%b pd=%h count=%0d unf=%b, required 1 %h 0 0",
                     pop_valid, pop_data, count, unf, exp_pd);
        end
        for (int i = 0; i < 4; i++) op(1, DATA_W'(8'hD0 + i), 0, 0, 0);
        op(1, 8'h99, 1, 0, 0);
        exp_pd = sb.pop_front();
        checks++;
        if (pop_valid !== 1 || pop_data !== exp_pd || count !== 4 || ovf !== 0 || top_data !== 8'h99) begin
            errors++;
            $display("FAIL pushpop_full: pv=%b pd=%h count=%0d ovf=%b top=%h, required 1 %h 4 0 99",
                     pop_valid, pop_data, count, ovf, top_data, exp_pd);
        end
        op(0, '0, 0, 1, 0);
    endtask

    task automatic test_flush();
        op(1, 8'h01, 0, 0, 0);
        op(1, 8'h02, 0, 0, 0);
        op(1, 8'h03, 0, 0, 0);
        op(1, 8'h04, 1, 1, 0);
        checks++;
        if (count !== 0 || pop_valid !== 0 || ovf !== 0 || unf !== 0 || empty !== 1) begin
            errors++;
            $display("FAIL flush: count=%0d pv=%b ovf=%b unf=%b empty=%b, required 0 0 0 0 1",
                     count, pop_valid, ovf, unf, empty);
        end
    endtask

    task automatic test_async_reset();
        op(1, 8'h61, 0, 0, 0);
        op(1, 8'h62, 1, 0, 0);
        void'(sb.pop_front());
        push_enable = 1; push_data = 8'h63; pop_enable = 0;
        #1 rst = 1;
        #1;
        model_reset();
        checks++;
        if (count !== 0 || pop_valid !== 0 || pop_data !== 0 || ovf !== 0 || unf !== 0 || empty !== 1) begin
            errors++;
            $display("FAIL async_rst: count=%0d pv=%b pd=%h ovf=%b unf=%b empty=%b, required 0 0 00 0 0 1",
                     count, pop_valid, pop_data, ovf, unf, empty);
        end
        @(posedge clk); #1;
        checks++;
        if (count !== 0) begin
            errors++;
            $display("FAIL rst_discard: count=%0d, required 0", count);
        end
        rst = 0;
        op(1, 8'h77, 0, 0, 0);
        checks++;
        if (count !== 1 || top_data !== 8'h77) begin
            errors++;
            $display("FAIL post_rst: count=%0d top=%h, required 1 77", count, top_data);
        end
        op(0, '0, 0, 1, 0);
    endtask

    task automatic test_random();
        bit pu, po, fl, ec;
        for (int i = 0; i < 300; i++) begin
            pu = ($urandom_range(0, 99) < 50);
            po = ($urandom_range(0, 99) < 45);
            fl = ($urandom_range(0, 99) < 4);
            ec = ($urandom_range(0, 99) < 20);
            op(pu, DATA_W'($urandom), po, fl, ec);
            checks++;
            if (pop_valid !== exp_valid || count !== CW'(model.size()) || top_data !== exp_top ||
                ovf !== m_ovf || unf !== m_unf || full !== (model.size() == DEPTH)) begin
                errors++;
                $display("FAIL random_%0d: pv=%b count=%0d top=%h ovf=%b unf=%b full=%b, required %b %0d %h %b %b %b",
                         i, pop_valid, count, top_data, ovf, unf, full,
                         exp_valid, model.size(), exp_top, m_ovf, m_unf, model.size() == DEPTH);
            end
            if (exp_valid && sb.size() > 0) begin
                exp_pd = sb.pop_front();
                checks++;
                if (pop_data !== exp_pd) begin
                    errors++;
                    $display("FAIL random_pd_%0d: pd=%h, required %h", i, pop_data, exp_pd);
                end
            end else begin
                checks++;
                if (pop_data !== m_pop_data) begin
                    errors++;
                    $display("FAIL random_hold_%0d: pd=%h, required %h", i, pop_data, m_pop_data);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_order();
        test_overflow();
        test_underflow();
        test_push_pop();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lifo_stack.md
LIFO_STACK -- requirements
Module: lifo_stack

Interface
REQ-001 SHALL have parameter DATA_W, default 8, entry width in bits (1..32).
REQ-002 SHALL have parameter DEPTH, default 16, number of entries (2..256, not required to be a power of two).
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 push_enable  input  1  push request this cycle.
REQ-007 push_data  input  DATA_W  data to push.
REQ-008 pop_enable  input  1  pop request this cycle.
REQ-009 flush  input  1  synchronous empty-the-stack request.
REQ-010 err_clr  input  1  clears sticky error flags; ignored when LIFO_STICKY_ERR_EN is undefined.
REQ-011 pop_data  output  DATA_W  registered popped value.
REQ-012 pop_valid  output  1  one-cycle strobe, pop_data updated this cycle.
REQ-013 top_data  output  DATA_W  current top entry; 0 when empty.
REQ-014 count  output  $clog2(DEPTH+1)  number of stored entries.
REQ-015 full  output  1  count == DEPTH.
REQ-016 empty  output  1  count == 0.
REQ-017 ovf  output  1  overflow error flag.
REQ-018 unf  output  1  underflow error flag.

Function
REQ-019 Storage: DEPTH x DATA_W register array; count is the write pointer; the top entry is at index count-1.
REQ-020 full, empty and top_data SHALL be combinational from count and the array, with no extra latency.
REQ-021 Push only, not full: mem[count] <= push_data and count+1 at the next edge.
REQ-022 Push only, full: push dropped, array and count unchanged, overflow event.
REQ-023 Pop only, not empty: pop_data <= mem[count-1], pop_valid=1 the next cycle (latency 1), count-1.
REQ-024 Pop only, empty: pop_valid stays 0, pop_data holds its value, underflow event.
REQ-025 Push and pop, not empty (including full): pop_data <= old top, pop_valid=1, mem[count-1] <= push_data, count unchanged, no error.
REQ-026 Push and pop, empty: bypass, pop_data <= push_data, pop_valid=1, count stays 0, no error.
REQ-027 flush SHALL take priority over push and pop: count <= 0, pop_valid=0, no error events; array contents are don't-care.
REQ-028 pop_valid SHALL be 0 in every cycle not following an accepted pop.
REQ-029 count SHALL never exceed DEPTH and never wrap below 0.

Reset
REQ-030 On rst assertion, immediately and independent of clk: count=0, pop_data=0, pop_valid=0, ovf=0, unf=0; array contents not reset.
REQ-031 Reset asserted mid-operation SHALL discard any request in flight; the first request after rst deasserts is processed normally at the next edge.

Configuration
REQ-032 Macro LIFO_STICKY_ERR_EN defined: ovf/unf set on their event and hold until an err_clr cycle clears them at the next edge; if an event and err_clr occur in the same cycle, the flag is set.
REQ-033 Macro undefined: ovf/unf are one-cycle pulses in the cycle after the event; err_clr has no effect.

Verification
REQ-034 Reset, then push 0x11,0x22,0x33 -> count=3, top_data=0x33; three pops -> pop_data 0x33,0x22,0x11 each with pop_valid, then empty=1.
REQ-035 DEPTH=4: five pushes -> full=1 after the 4th; the 5th sets ovf; count=4; top_data = the 4th value.
REQ-036 Pop on empty -> unf=1, pop_valid=0, pop_data unchanged; sticky build: unf holds until err_clr, pulse build: clears after 1 cycle.
REQ-037 Stack [0xA0,0xA1], push 0xB0 + pop together -> pop_data=0xA1, count=2, top_data=0xB0; on empty, push 0x5C + pop -> pop_data=0x5C, count=0.
REQ-038 count=3 with flush+push+pop together -> count=0, pop_valid=0, no error; async rst mid-burst -> all outputs at reset values before the next clk edge.
